// File: rtl/muller_c_hs_driver.sv
// Clocked four-phase handshake driver for a Muller C-element, with hold/timeout checks.
// Optional MULLER_HS_ALT_ORDER_EN: lead input alternates A/B on each completed handshake.
module muller_c_hs_driver #(
    parameter int SKEW_CYC    = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             loop_en,
    input  logic             clr_err,
    input  logic             c_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             err_hold,
    output logic             err_timeout,
    output logic [CNT_W-1:0] hs_cnt
);
    localparam int SKEW_W = $clog2(SKEW_CYC + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'(SKEW_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SET_L,
        SET_T,
        WAIT_HI,
        CLR_L,
        CLR_T,
        WAIT_LO,
        DONE_ST
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   c_sync;
    logic [SKEW_W-1:0]      skew_cnt;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   lead_is_b;

    // NOTE: synchronizer flops are reset too, so c_sync reads 0 right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], c_in};
        end
    end

    assign c_sync = sync_q[SYNC_STAGES-1];

`ifdef MULLER_HS_ALT_ORDER_EN
    logic order_q;

    // Toggles on the same edge that enters DONE_ST, so a re-arm already uses the new order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_q <= 1'b0;
        end else if (state == WAIT_LO && !c_sync) begin
            order_q <= ~order_q;
        end
    end

    assign lead_is_b = order_q;
`else
    assign lead_is_b = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_out       <= 1'b0;
            b_out       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_hold    <= 1'b0;
            err_timeout <= 1'b0;
            hs_cnt      <= '0;
            skew_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            done <= 1'b0;
            // NOTE: the last non-blocking assignment wins, so an error set below beats this clear.
            if (clr_err) begin
                err_hold    <= 1'b0;
                err_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SET_L;
                        busy     <= 1'b1;
                        skew_cnt <= '0;
                        if (lead_is_b) b_out <= 1'b1;
                        else           a_out <= 1'b1;
                    end
                end

                SET_L: begin
                    if (c_sync) err_hold <= 1'b1;
                    if (skew_cnt == SKEW_LAST) begin
                        state <= SET_T;
                        if (lead_is_b) a_out <= 1'b1;
                        else           b_out <= 1'b1;
                    end else begin
                        skew_cnt <= skew_cnt + 1'b1;
                    end
                end

                SET_T: begin
                    state    <= WAIT_HI;
                    wait_cnt <= '0;
                end

                WAIT_HI: begin
                    if (c_sync) begin
                        state    <= CLR_L;
                        skew_cnt <= '0;
                        if (lead_is_b) b_out <= 1'b0;
                        else           a_out <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        a_out       <= 1'b0;
                        b_out       <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                CLR_L: begin
                    if (!c_sync) err_hold <= 1'b1;
                    if (skew_cnt == SKEW_LAST) begin
                        state <= CLR_T;
                        if (lead_is_b) a_out <= 1'b0;
                        else           b_out <= 1'b0;
                    end else begin
                        skew_cnt <= skew_cnt + 1'b1;
                    end
                end

                CLR_T: begin
                    state    <= WAIT_LO;
                    wait_cnt <= '0;
                end

                WAIT_LO: begin
                    if (!c_sync) begin
                        state  <= DONE_ST;
                        done   <= 1'b1;
                        hs_cnt <= hs_cnt + 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        a_out       <= 1'b0;
                        b_out       <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DONE_ST: begin
                    if (loop_en) begin
                        state    <= SET_L;
                        skew_cnt <= '0;
                        if (lead_is_b) b_out <= 1'b1;
                        else           a_out <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
